// File: rtl/uart_host_bridge.sv
// uart_host_bridge: buffers characters between a host stream interface and a
// character-level UART transceiver.
//   sys_clk_i / sys_rst_i      : clock and synchronous active-high reset
//   host_tx_*                  : host -> TX FIFO (valid/ready push)
//   host_rx_*                  : RX FIFO -> host (first-word-fall-through)
//   xcvr_tx_*                  : one-cycle strobe per character, done handshake
//   xcvr_rx_*                  : received character with one-cycle done
//   tx_level_o / rx_level_o    : FIFO occupancy
//   rx_overrun_cnt_o           : saturating count of dropped RX characters
//   tx_timeout_cnt_o           : saturating count of TX done timeouts
module uart_host_bridge #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned TX_DEPTH   = 16,
    parameter int unsigned RX_DEPTH   = 16,
    parameter int unsigned TX_TIMEOUT = 0
) (
    input  logic                        sys_clk_i,
    input  logic                        sys_rst_i,
    input  logic [DATA_W-1:0]           host_tx_data_i,
    input  logic                        host_tx_valid_i,
    output logic                        host_tx_ready_o,
    output logic [DATA_W-1:0]           host_rx_data_o,
    output logic                        host_rx_valid_o,
    input  logic                        host_rx_ready_i,
    output logic [DATA_W-1:0]           xcvr_tx_data_o,
    output logic                        xcvr_tx_wr_o,
    input  logic                        xcvr_tx_done_i,
    input  logic [DATA_W-1:0]           xcvr_rx_data_i,
    input  logic                        xcvr_rx_done_i,
    output logic [$clog2(TX_DEPTH):0]   tx_level_o,
    output logic [$clog2(RX_DEPTH):0]   rx_level_o,
    output logic [15:0]                 rx_overrun_cnt_o,
    output logic [15:0]                 tx_timeout_cnt_o
);

    localparam int unsigned TX_AW = $clog2(TX_DEPTH);
    localparam int unsigned TX_LW = TX_AW + 1;
    localparam int unsigned RX_AW = $clog2(RX_DEPTH);
    localparam int unsigned RX_LW = RX_AW + 1;
    localparam int unsigned WC_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } tx_state_e;

    // ---------------- TX FIFO ----------------
    logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];
    logic [TX_AW-1:0]  tx_wr_ptr_q;
    logic [TX_AW-1:0]  tx_rd_ptr_q;
    logic [TX_LW-1:0]  tx_level_q;
    logic              tx_push;
    logic              tx_pop;

    // ---------------- TX FSM ----------------
    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [15:0]       timeout_cnt_q, timeout_cnt_d;
    logic              tx_wr_q;

    // ---------------- RX FIFO ----------------
    logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];
    logic [RX_AW-1:0]  rx_wr_ptr_q;
    logic [RX_AW-1:0]  rx_rd_ptr_q;
    logic [RX_LW-1:0]  rx_level_q;
    logic [15:0]       overrun_cnt_q;
    logic              rx_pop;
    logic              rx_full;
    logic              rx_wr;
    logic              rx_drop;

    // Ready is decoded from the registered level only, so it never depends on
    // same-cycle host or transceiver inputs.
    assign host_tx_ready_o = (tx_level_q != TX_LW'(TX_DEPTH));
    assign tx_push         = host_tx_valid_i && host_tx_ready_o;

    // TX state register
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q       <= ST_IDLE;
            tx_data_q     <= '0;
            wait_cnt_q    <= '0;
            timeout_cnt_q <= '0;
            tx_wr_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            tx_wr_q       <= (state_d == ST_ISSUE);
        end
    end

    // TX next-state: pop in IDLE, strobe in ISSUE, wait for done or timeout
    always_comb begin
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        tx_pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_level_q != '0) begin
                    tx_pop    = 1'b1;
                    tx_data_d = tx_mem_q[tx_rd_ptr_q];
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (xcvr_tx_done_i) begin
                    state_d = ST_IDLE;
                end else if ((TX_TIMEOUT != 0) && (wait_cnt_q == WC_W'(TX_TIMEOUT - 1))) begin
                    // wait_cnt_q counts completed WAIT cycles before this edge
                    state_d = ST_IDLE;
                    if (timeout_cnt_q != 16'hFFFF) begin
                        timeout_cnt_d = timeout_cnt_q + 16'd1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // TX FIFO storage
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i && tx_push) begin
            tx_mem_q[tx_wr_ptr_q] <= host_tx_data_i;
        end
    end

    // TX FIFO pointers and level; pointers wrap naturally at power-of-2 depth
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_level_q  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + TX_AW'(1);
            if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + TX_AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_level_q <= tx_level_q + TX_LW'(1);
                2'b01:   tx_level_q <= tx_level_q - TX_LW'(1);
                default: tx_level_q <= tx_level_q;
            endcase
        end
    end

    // RX write/drop decisions; a same-cycle pop frees the slot for a full FIFO
    assign host_rx_valid_o = (rx_level_q != '0);
    assign host_rx_data_o  = rx_mem_q[rx_rd_ptr_q];
    assign rx_pop          = host_rx_valid_o && host_rx_ready_i;
    assign rx_full         = (rx_level_q == RX_LW'(RX_DEPTH));
    assign rx_wr           = xcvr_rx_done_i && (!rx_full || rx_pop);
    assign rx_drop         = xcvr_rx_done_i && rx_full && !rx_pop;

    // RX FIFO storage
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i && rx_wr) begin
            rx_mem_q[rx_wr_ptr_q] <= xcvr_rx_data_i;
        end
    end

    // RX FIFO pointers, level and overrun counter
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            rx_wr_ptr_q   <= '0;
            rx_rd_ptr_q   <= '0;
            rx_level_q    <= '0;
            overrun_cnt_q <= '0;
        end else begin
            if (rx_wr)  rx_wr_ptr_q <= rx_wr_ptr_q + RX_AW'(1);
            if (rx_pop) rx_rd_ptr_q <= rx_rd_ptr_q + RX_AW'(1);
            case ({rx_wr, rx_pop})
                2'b10:   rx_level_q <= rx_level_q + RX_LW'(1);
                2'b01:   rx_level_q <= rx_level_q - RX_LW'(1);
                default: rx_level_q <= rx_level_q;
            endcase
            if (rx_drop && (overrun_cnt_q != 16'hFFFF)) begin
                overrun_cnt_q <= overrun_cnt_q + 16'd1;
            end
        end
    end

    assign xcvr_tx_data_o   = tx_data_q;
    assign xcvr_tx_wr_o     = tx_wr_q;
    assign tx_level_o       = tx_level_q;
    assign rx_level_o       = rx_level_q;
    assign rx_overrun_cnt_o = overrun_cnt_q;
    assign tx_timeout_cnt_o = timeout_cnt_q;

endmodule

// File: tb/tb_uart_host_bridge.sv
// Directed bench for uart_host_bridge: one default instance and one with a
// 100-cycle TX timeout, sharing clock and reset.
module tb_uart_host_bridge;

    localparam int unsigned DW = 8;
    localparam int unsigned LW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    // default instance
    logic [DW-1:0] tx_data, rx_data, x_tx_data, x_rx_data;
    logic          tx_valid, tx_ready, rx_valid, rx_ready;
    logic          x_tx_wr, x_tx_done, x_rx_done;
    logic [LW-1:0] tx_level, rx_level;
    logic [15:0]   ovr_cnt, to_cnt;
    // timeout instance
    logic [DW-1:0] t_tx_data, t_rx_data, t_x_tx_data, t_x_rx_data;
    logic          t_tx_valid, t_tx_ready, t_rx_valid, t_rx_ready;
    logic          t_x_tx_wr, t_x_tx_done, t_x_rx_done;
    logic [LW-1:0] t_tx_level, t_rx_level;
    logic [15:0]   t_ovr_cnt, t_to_cnt;

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] tx_seen[$];

    uart_host_bridge dut (
        .sys_clk_i(clk), .sys_rst_i(rst),
        .host_tx_data_i(tx_data), .host_tx_valid_i(tx_valid), .host_tx_ready_o(tx_ready),
        .host_rx_data_o(rx_data), .host_rx_valid_o(rx_valid), .host_rx_ready_i(rx_ready),
        .xcvr_tx_data_o(x_tx_data), .xcvr_tx_wr_o(x_tx_wr), .xcvr_tx_done_i(x_tx_done),
        .xcvr_rx_data_i(x_rx_data), .xcvr_rx_done_i(x_rx_done),
        .tx_level_o(tx_level), .rx_level_o(rx_level),
        .rx_overrun_cnt_o(ovr_cnt), .tx_timeout_cnt_o(to_cnt)
    );

    uart_host_bridge #(.TX_TIMEOUT(100)) dut_to (
        .sys_clk_i(clk), .sys_rst_i(rst),
        .host_tx_data_i(t_tx_data), .host_tx_valid_i(t_tx_valid), .host_tx_ready_o(t_tx_ready),
        .host_rx_data_o(t_rx_data), .host_rx_valid_o(t_rx_valid), .host_rx_ready_i(t_rx_ready),
        .xcvr_tx_data_o(t_x_tx_data), .xcvr_tx_wr_o(t_x_tx_wr), .xcvr_tx_done_i(t_x_tx_done),
        .xcvr_rx_data_i(t_x_rx_data), .xcvr_rx_done_i(t_x_rx_done),
        .tx_level_o(t_tx_level), .rx_level_o(t_rx_level),
        .rx_overrun_cnt_o(t_ovr_cnt), .tx_timeout_cnt_o(t_to_cnt)
    );

    // record every transmit strobe of the default instance
    always @(negedge clk) begin
        if (!rst && x_tx_wr) tx_seen.push_back(x_tx_data);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_done();
        x_tx_done = 1'b1;
        tick();
        x_tx_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
        x_tx_done = 1'b0; x_rx_data = '0; x_rx_done = 1'b0;
        t_tx_data = '0; t_tx_valid = 1'b0; t_rx_ready = 1'b0;
        t_x_tx_done = 1'b0; t_x_rx_data = '0; t_x_rx_done = 1'b0;

        // reset, with pushes and RX writes offered during reset
        tick();
        tx_valid = 1'b1; tx_data = 8'h99; x_rx_done = 1'b1; x_rx_data = 8'h98;
        tick(); tick();
        rst = 1'b0; tx_valid = 1'b0; x_rx_done = 1'b0;
        check_val("rst_tx_ready", 32'(tx_ready), 32'd1);
        check_val("rst_rx_valid", 32'(rx_valid), 32'd0);
        check_val("rst_tx_wr", 32'(x_tx_wr), 32'd0);
        check_val("rst_tx_data", 32'(x_tx_data), 32'h00);
        check_val("rst_ovr_cnt", 32'(ovr_cnt), 32'd0);
        check_val("rst_to_cnt", 32'(to_cnt), 32'd0);
        tick();
        check_val("rst_disc_tx_level", 32'(tx_level), 32'd0);
        check_val("rst_disc_rx_level", 32'(rx_level), 32'd0);

        // single character, transceiver never finishes
        tx_seen.delete();
        tx_valid = 1'b1; tx_data = 8'h41;
        tick();
        tx_valid = 1'b0;
        check_val("c1_wr_early", 32'(x_tx_wr), 32'd0);
        check_val("c1_level", 32'(tx_level), 32'd1);
        tick();
        check_val("c1_wr", 32'(x_tx_wr), 32'd1);
        check_val("c1_data", 32'(x_tx_data), 32'h41);
        tick();
        check_val("c1_wr_once", 32'(x_tx_wr), 32'd0);
        repeat (50) tick();
        check_val("c1_strobes", 32'(tx_seen.size()), 32'd1);
        check_val("c1_no_timeout", 32'(to_cnt), 32'd0);
        tx_valid = 1'b1; tx_data = 8'h42;
        tick();
        tx_valid = 1'b0;
        repeat (5) tick();
        check_val("c1_still_wait", 32'(tx_seen.size()), 32'd1);
        check_val("c1_held_data", 32'(x_tx_data), 32'h41);
        check_val("c1_second_queued", 32'(tx_level), 32'd1);
        send_done();
        tick();
        check_val("c1_next_wr", 32'(x_tx_wr), 32'd1);
        check_val("c1_next_data", 32'(x_tx_data), 32'h42);
        tick();
        send_done();
        tick();

        // 17 back-to-back pushes against a stalled transceiver
        tx_seen.delete();
        for (int i = 0; i < 17; i++) begin
            check_val("fill_ready", 32'(tx_ready), 32'd1);
            tx_valid = 1'b1; tx_data = DW'(8'h10 + i);
            tick();
        end
        tx_data = 8'hEE;
        check_val("full_level", 32'(tx_level), 32'd16);
        check_val("full_ready", 32'(tx_ready), 32'd0);
        tick();
        tx_valid = 1'b0;
        check_val("full_no_push", 32'(tx_level), 32'd16);
        for (int i = 0; i < 17; i++) begin
            send_done();
            tick(); tick();
        end
        check_val("drain_count", 32'(tx_seen.size()), 32'd17);
        for (int i = 0; i < 17; i++) begin
            if (i < tx_seen.size()) check_val("drain_order", 32'(tx_seen[i]), 32'(8'h10 + i));
        end
        check_val("drain_level", 32'(tx_level), 32'd0);

        // RX overrun: 18 characters with the host stalled
        for (int i = 0; i < 18; i++) begin
            x_rx_done = 1'b1; x_rx_data = DW'(8'hA0 + i);
            tick();
        end
        x_rx_done = 1'b0;
        check_val("ovr_level", 32'(rx_level), 32'd16);
        check_val("ovr_cnt", 32'(ovr_cnt), 32'd2);
        check_val("ovr_head", 32'(rx_data), 32'hA0);
        // full FIFO: write coincides with pop
        x_rx_done = 1'b1; x_rx_data = 8'hC0; rx_ready = 1'b1;
        tick();
        x_rx_done = 1'b0;
        check_val("swap_level", 32'(rx_level), 32'd16);
        check_val("swap_cnt", 32'(ovr_cnt), 32'd2);
        for (int i = 1; i < 16; i++) begin
            check_val("rx_order", 32'(rx_data), 32'(8'hA0 + i));
            tick();
        end
        check_val("rx_last", 32'(rx_data), 32'hC0);
        tick();
        rx_ready = 1'b0;
        check_val("rx_empty", 32'(rx_valid), 32'd0);
        check_val("rx_empty_level", 32'(rx_level), 32'd0);

        // timeout instance: 100 WAIT cycles, then next character issues
        t_tx_valid = 1'b1; t_tx_data = 8'h55;
        tick();
        t_tx_data = 8'h66;
        tick();
        t_tx_valid = 1'b0;
        check_val("to_wr1", 32'(t_x_tx_wr), 32'd1);
        check_val("to_data1", 32'(t_x_tx_data), 32'h55);
        tick();
        repeat (99) tick();
        check_val("to_before", 32'(t_to_cnt), 32'd0);
        tick();
        check_val("to_after", 32'(t_to_cnt), 32'd1);
        check_val("to_idle_wr", 32'(t_x_tx_wr), 32'd0);
        check_val("to_idle_level", 32'(t_tx_level), 32'd1);
        tick();
        check_val("to_wr2", 32'(t_x_tx_wr), 32'd1);
        check_val("to_data2", 32'(t_x_tx_data), 32'h66);
        // done during ISSUE must be ignored
        t_x_tx_done = 1'b1;
        tick();
        t_x_tx_done = 1'b0;
        repeat (99) tick();
        check_val("to_issue_done_before", 32'(t_to_cnt), 32'd1);
        tick();
        check_val("to_issue_done_after", 32'(t_to_cnt), 32'd2);

        // reset during WAIT with five characters queued
        tx_seen.delete();
        for (int i = 0; i < 6; i++) begin
            tx_valid = 1'b1; tx_data = DW'(8'h30 + i);
            tick();
        end
        tx_valid = 1'b0;
        tick();
        check_val("wrst_level", 32'(tx_level), 32'd5);
        check_val("wrst_strobes", 32'(tx_seen.size()), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("wrst_level0", 32'(tx_level), 32'd0);
        check_val("wrst_wr", 32'(x_tx_wr), 32'd0);
        check_val("wrst_data", 32'(x_tx_data), 32'h00);
        check_val("wrst_to_cnt", 32'(t_to_cnt), 32'd0);
        repeat (10) tick();
        send_done();
        repeat (5) tick();
        check_val("wrst_no_strobe", 32'(tx_seen.size()), 32'd1);
        tx_valid = 1'b1; tx_data = 8'h77;
        tick();
        tx_valid = 1'b0;
        tick();
        check_val("wrst_new_wr", 32'(x_tx_wr), 32'd1);
        check_val("wrst_new_data", 32'(x_tx_data), 32'h77);
        tick();
        send_done();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
